branch_cmp_pipe: RTL

- Parametrised, pipelined branch comparator.
- Generalises the single-cycle combinational rs1/rs2 comparator: XLEN-wide operands, branch condition fully decoded from funct3, STAGES-deep registered pipeline with valid/ready handshake, flush, tag passthrough, saturating taken/compare performance counters.
- Sits between register-read and the fetch redirect logic of the pipelined core.

---
 rtl/branch_cmp_pipe.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/branch_cmp_pipe.sv
// branch_cmp_pipe: pipelined rs1/rs2 branch comparator with valid/ready
// handshake, flush, tag passthrough and saturating perf counters.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (rs1_data, rs2_data, funct3, in_tag)
//   flush               drop every in-flight request
//   out_valid/out_ready result handshake (breq, brlt, taken, illegal, out_tag)
//   clr_cnt             clear cmp_count / taken_count
module branch_cmp_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [2:0]       funct3,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             breq,
    output logic             brlt,
    output logic             taken,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cmp_count,
    output logic [CNT_W-1:0] taken_count
);

    if (STAGES < 1 || STAGES > 2) begin : g_bad_stages
        $error("branch_cmp_pipe: STAGES must be 1 or 2");
    end

    typedef struct packed {
        logic             valid;
        logic             breq;
        logic             brlt;
        logic             taken;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } stage_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    stage_t st_q [STAGES];
    stage_t st_d [STAGES];

    logic cmp_eq;
    logic cmp_lt;
    logic cmp_taken;
    logic cmp_ill;
    logic use_signed;
    logic adv_last;
    logic adv_first;
    logic accept;
    logic out_hs;

    logic [CNT_W-1:0] cmp_cnt_q;
    logic [CNT_W-1:0] cmp_cnt_d;
    logic [CNT_W-1:0] tkn_cnt_q;
    logic [CNT_W-1:0] tkn_cnt_d;

    // Illegal encodings still report a signed less-than.
    always_comb begin
        cmp_ill    = (funct3[2:1] == 2'b01);
        use_signed = !funct3[1] || cmp_ill;
        cmp_eq     = (rs1_data == rs2_data);
        if (use_signed) begin
            cmp_lt = $signed(rs1_data) < $signed(rs2_data);
        end else begin
            cmp_lt = rs1_data < rs2_data;
        end
        cmp_taken = 1'b0;
        unique case (funct3)
            3'b000:  cmp_taken = cmp_eq;
            3'b001:  cmp_taken = !cmp_eq;
            3'b100:  cmp_taken = cmp_lt;
            3'b101:  cmp_taken = !cmp_lt;
            3'b110:  cmp_taken = cmp_lt;
            3'b111:  cmp_taken = !cmp_lt;
            default: cmp_taken = 1'b0;
        endcase
    end

    // A stage moves when it is empty or its successor moves.
    assign adv_last  = !st_q[STAGES-1].valid || out_ready;
    assign adv_first = (STAGES == 1) ? adv_last
                                     : (!st_q[0].valid || adv_last);
    assign in_ready  = adv_first && !flush;
    assign accept    = in_valid && in_ready;
    assign out_hs    = st_q[STAGES-1].valid && out_ready;

    always_comb begin
        st_d = st_q;
        if (STAGES > 1 && adv_last) begin
            st_d[STAGES-1] = st_q[0];
        end
        if (adv_first) begin
            st_d[0].valid = accept;
            // Data only loads on accept so bubbles keep the old result.
            if (accept) begin
                st_d[0].breq    = cmp_eq;
                st_d[0].brlt    = cmp_lt;
                st_d[0].taken   = cmp_taken && !cmp_ill;
                st_d[0].illegal = cmp_ill;
                st_d[0].tag     = in_tag;
            end
        end
        if (flush) begin
            for (int k = 0; k < STAGES; k++) begin
                st_d[k].valid = 1'b0;
            end
        end
    end

    // A result consumed in a flush cycle is still counted.
    always_comb begin
        cmp_cnt_d = cmp_cnt_q;
        tkn_cnt_d = tkn_cnt_q;
        if (clr_cnt) begin
            cmp_cnt_d = '0;
            tkn_cnt_d = '0;
        end else if (out_hs) begin
            if (cmp_cnt_q != CNT_MAX) begin
                cmp_cnt_d = cmp_cnt_q + CNT_W'(1);
            end
            if (st_q[STAGES-1].taken && tkn_cnt_q != CNT_MAX) begin
                tkn_cnt_d = tkn_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
            cmp_cnt_q <= '0;
            tkn_cnt_q <= '0;
        end else begin
            st_q      <= st_d;
            cmp_cnt_q <= cmp_cnt_d;
            tkn_cnt_q <= tkn_cnt_d;
        end
    end

    assign out_valid   = st_q[STAGES-1].valid;
    assign breq        = st_q[STAGES-1].breq;
    assign brlt        = st_q[STAGES-1].brlt;
    assign taken       = st_q[STAGES-1].taken;
    assign illegal     = st_q[STAGES-1].illegal;
    assign out_tag     = st_q[STAGES-1].tag;
    assign cmp_count   = cmp_cnt_q;
    assign taken_count = tkn_cnt_q;

endmodule
